// File: rtl/uart_tx_periph.sv
// Purpose: memory-mapped 8N1 UART transmitter with a small TX FIFO and DATA/STATUS/CTRL registers.
// Latency: register reads return one cycle after ren; a byte written to an idle, empty FIFO drives its start bit two cycles after the write.
// Backpressure: none on the bus; a DATA write to a full FIFO drops the byte and sets the sticky overflow flag.
module uart_tx_periph #(
    parameter int CLKS_PER_BIT = 104,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wen,
    input  logic        ren,
    input  logic [1:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        tx,
    output logic        busy
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int BW = $clog2(CLKS_PER_BIT);

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    // FIFO storage and bookkeeping
    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          fifo_full;
    logic          fifo_empty;
    logic          push_req;
    logic          push;
    logic          pop;

    // Control / status registers
    logic          enable;
    logic          overflow;
    logic [31:0]   status_word;
    logic [4:0]    count_field;

    // Transmit FSM state
    state_t        state;
    state_t        state_nxt;
    logic [BW-1:0] baud_cnt;
    logic [BW-1:0] baud_nxt;
    logic [2:0]    bit_cnt;
    logic [2:0]    bit_nxt;
    logic [7:0]    shift;
    logic [7:0]    shift_nxt;
    logic          tx_nxt;
    logic          busy_nxt;
    logic          baud_end;

    // Upper write-data bits have no meaning in any register
    logic          unused_wdata_hi;
    assign unused_wdata_hi = ^wdata[31:8];

    assign fifo_full  = (count == CW'(FIFO_DEPTH));
    assign fifo_empty = (count == '0);
    assign push_req   = wen && (addr == ADDR_DATA);
    // Fullness is judged before any same-cycle pop, so a push to a full FIFO is always dropped
    assign push       = push_req && !fifo_full;
    assign baud_end   = (baud_cnt == BW'(CLKS_PER_BIT - 1));

    assign count_field = 5'(count);
    assign status_word = {23'd0, count_field, overflow, busy, fifo_empty, fifo_full};

    // FIFO data array; contents need no reset because count gates every read
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= wdata[7:0];
        end
    end

    // FIFO pointers and occupancy count
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Bus-visible registers and the registered read port (reads see pre-write values)
    always_ff @(posedge clk) begin
        if (rst) begin
            enable   <= 1'b1;
            overflow <= 1'b0;
            rdata    <= '0;
        end else begin
            if (wen && (addr == ADDR_CTRL)) begin
                enable <= wdata[0];
            end
            if (push_req && fifo_full) begin
                overflow <= 1'b1;
            end else if (wen && (addr == ADDR_STATUS) && wdata[3]) begin
                overflow <= 1'b0;
            end
            if (ren) begin
                case (addr)
                    ADDR_STATUS: rdata <= status_word;
                    ADDR_CTRL:   rdata <= {31'd0, enable};
                    default:     rdata <= '0;
                endcase
            end
        end
    end

    // Transmit FSM state, counters, shifter and registered line outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            tx       <= 1'b1;
            busy     <= 1'b0;
        end else begin
            state    <= state_nxt;
            baud_cnt <= baud_nxt;
            bit_cnt  <= bit_nxt;
            shift    <= shift_nxt;
            tx       <= tx_nxt;
            busy     <= busy_nxt;
        end
    end

    // Next-state logic; line outputs are derived from the next state so they register with it
    always_comb begin
        state_nxt = state;
        baud_nxt  = baud_cnt;
        bit_nxt   = bit_cnt;
        shift_nxt = shift;
        pop       = 1'b0;
        tx_nxt    = 1'b1;
        busy_nxt  = 1'b0;

        case (state)
            S_IDLE: begin
                if (enable && !fifo_empty) begin
                    pop       = 1'b1;
                    shift_nxt = fifo_mem[rd_ptr];
                    baud_nxt  = '0;
                    state_nxt = S_START;
                end
            end
            S_START: begin
                if (baud_end) begin
                    baud_nxt  = '0;
                    bit_nxt   = '0;
                    state_nxt = S_DATA;
                end else begin
                    baud_nxt = baud_cnt + BW'(1);
                end
            end
            S_DATA: begin
                if (baud_end) begin
                    baud_nxt  = '0;
                    shift_nxt = {1'b0, shift[7:1]};
                    if (bit_cnt == 3'd7) begin
                        bit_nxt   = '0;
                        state_nxt = S_STOP;
                    end else begin
                        bit_nxt = bit_cnt + 3'd1;
                    end
                end else begin
                    baud_nxt = baud_cnt + BW'(1);
                end
            end
            S_STOP: begin
                if (baud_end) begin
                    baud_nxt = '0;
                    // Chain straight into the next start bit so queued bytes leave with no gap
                    if (enable && !fifo_empty) begin
                        pop       = 1'b1;
                        shift_nxt = fifo_mem[rd_ptr];
                        state_nxt = S_START;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end else begin
                    baud_nxt = baud_cnt + BW'(1);
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        case (state_nxt)
            S_START: tx_nxt = 1'b0;
            S_DATA:  tx_nxt = shift_nxt[0];
            default: tx_nxt = 1'b1;
        endcase
        busy_nxt = (state_nxt != S_IDLE);
    end
endmodule

// File: tb/tb_uart_tx_periph.sv
// Scoreboard bench for uart_tx_periph: stimulus queues expected reads, line samples and bytes;
// independent monitors pop and compare as the DUT produces read data and serial frames.
`timescale 1ns/1ps
module tb_uart_tx_periph;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        wen;
    logic        ren;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        tx;
    logic        busy;

    always #5 clk = ~clk;

    uart_tx_periph #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .wen   (wen),
        .ren   (ren),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata),
        .tx    (tx),
        .busy  (busy)
    );

    typedef struct packed {
        logic chk;
        logic tx;
        logic busy;
    } line_t;

    line_t       line_q[$];
    logic [31:0] rd_q[$];
    logic [7:0]  byte_q[$];

    int vectors     = 0;
    int miscompares = 0;
    int cycle       = 0;

    logic        rd_vld = 1'b0;
    logic [31:0] rd_exp;
    line_t       line_e;
    logic [7:0]  rx_byte;
    logic [7:0]  rx_exp;
    logic        rx_abort;
    logic        rx_stop;

    always @(posedge clk) cycle <= cycle + 1;
    always @(posedge clk) rd_vld <= ren;

    // Read-data monitor: one expected word per issued read, checked the cycle after
    always @(negedge clk) begin
        if (rd_vld) begin
            vectors++;
            if (rd_q.size() == 0) begin
                miscompares++;
                $display("FAIL rd_unexpected cycle=%0d rdata=%h required=no read outstanding", cycle, rdata);
            end else begin
                rd_exp = rd_q.pop_front();
                if (rdata !== rd_exp) begin
                    miscompares++;
                    $display("FAIL rd cycle=%0d rdata=%h required=%h", cycle, rdata, rd_exp);
                end
            end
        end
    end

    // Line monitor: cycle-exact tx/busy expectations
    always @(negedge clk) begin
        if (line_q.size() > 0) begin
            line_e = line_q.pop_front();
            if (line_e.chk) begin
                vectors++;
                if (tx !== line_e.tx || busy !== line_e.busy) begin
                    miscompares++;
                    $display("FAIL line cycle=%0d tx/busy=%b/%b required=%b/%b",
                             cycle, tx, busy, line_e.tx, line_e.busy);
                end
            end
        end
    end

    task automatic rx_wait(input int n, inout logic ab);
        for (int j = 0; j < n; j++) begin
            @(negedge clk);
            if (rst !== 1'b0) ab = 1'b1;
        end
    endtask

    // Serial receiver: decodes frames mid-bit and checks them against queued bytes
    initial begin : rx_mon
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && tx === 1'b0) begin
                rx_abort = 1'b0;
                rx_wait(2, rx_abort);
                for (int i = 0; i < 8; i++) begin
                    rx_wait(CPB, rx_abort);
                    rx_byte[i] = tx;
                end
                rx_wait(CPB, rx_abort);
                rx_stop = tx;
                if (!rx_abort) begin
                    vectors++;
                    if (byte_q.size() == 0) begin
                        miscompares++;
                        $display("FAIL rx_unexpected cycle=%0d byte=%h required=no frame", cycle, rx_byte);
                    end else begin
                        rx_exp = byte_q.pop_front();
                        if (rx_byte !== rx_exp || rx_stop !== 1'b1) begin
                            miscompares++;
                            $display("FAIL rx_byte cycle=%0d byte=%h stop=%b required=%h stop=1",
                                     cycle, rx_byte, rx_stop, rx_exp);
                        end
                    end
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        wen = 1'b1; addr = a; wdata = d;
        cyc(1);
        wen = 1'b0; wdata = '0;
    endtask

    task automatic bus_read(input logic [1:0] a, input logic [31:0] expv);
        ren = 1'b1; addr = a;
        rd_q.push_back(expv);
        cyc(1);
        ren = 1'b0;
    endtask

    task automatic bus_write_read(input logic [1:0] a, input logic [31:0] d, input logic [31:0] expv);
        wen = 1'b1; ren = 1'b1; addr = a; wdata = d;
        rd_q.push_back(expv);
        cyc(1);
        wen = 1'b0; ren = 1'b0; wdata = '0;
    endtask

    task automatic push_line(input logic c, input logic t, input logic b, input int n);
        line_t e;
        e.chk = c; e.tx = t; e.busy = b;
        for (int i = 0; i < n; i++) line_q.push_back(e);
    endtask

    // One 8N1 frame: start low, data LSB first, stop high, busy throughout
    task automatic expect_frame(input logic [7:0] b);
        push_line(1'b1, 1'b0, 1'b1, CPB);
        for (int i = 0; i < 8; i++) push_line(1'b1, b[i], 1'b1, CPB);
        push_line(1'b1, 1'b1, 1'b1, CPB);
        byte_q.push_back(b);
    endtask

    task automatic wait_drain(input int limit);
        for (int i = 0; i < limit && line_q.size() > 0; i++) @(posedge clk);
        #1;
        if (line_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout left=%0d required=0", line_q.size());
            line_q.delete();
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog simulation did not complete within time limit");
        $fatal(1, "timeout");
    end

    initial begin : stim
        rst = 1'b1; wen = 1'b0; ren = 1'b0; addr = '0; wdata = '0;
        cyc(3);
        rst = 1'b0;

        // Reset state and register map
        push_line(1'b1, 1'b1, 1'b0, 4);
        bus_read(2'd1, 32'h002);
        bus_read(2'd2, 32'h001);
        bus_read(2'd0, 32'h000);
        bus_read(2'd3, 32'h000);
        wait_drain(20);

        // Single frame 0xA5 with cycle-exact timing and status around the pop
        push_line(1'b1, 1'b1, 1'b0, 2);
        expect_frame(8'hA5);
        push_line(1'b1, 1'b1, 1'b0, 1);
        bus_write(2'd0, 32'h0000_00A5);
        bus_read(2'd1, 32'h010);
        bus_read(2'd1, 32'h006);
        wait_drain(200);

        // Clear enable during bit 3 of the first of three bytes
        push_line(1'b1, 1'b1, 1'b0, 2);
        expect_frame(8'h11);
        push_line(1'b1, 1'b1, 1'b0, 1);
        bus_write(2'd0, 32'h11);
        bus_write(2'd0, 32'h22);
        bus_write(2'd0, 32'h33);
        cyc(15);
        bus_write(2'd2, 32'h0);
        wait_drain(200);
        push_line(1'b1, 1'b1, 1'b0, 60);
        wait_drain(200);
        bus_read(2'd1, 32'h020);

        // Re-enable drains the retained bytes back to back
        push_line(1'b1, 1'b1, 1'b0, 2);
        expect_frame(8'h22);
        expect_frame(8'h33);
        push_line(1'b1, 1'b1, 1'b0, 1);
        bus_write(2'd2, 32'h1);
        wait_drain(300);
        bus_read(2'd1, 32'h002);

        // Overflow: disable, push five bytes into a four-deep FIFO
        bus_write_read(2'd2, 32'h0, 32'h001);
        bus_read(2'd2, 32'h000);
        for (int i = 1; i <= 5; i++) bus_write(2'd0, 32'(i));
        bus_read(2'd1, 32'h049);
        bus_write(2'd1, 32'h8);
        bus_read(2'd1, 32'h041);
        push_line(1'b1, 1'b1, 1'b0, 2);
        for (int i = 1; i <= 4; i++) expect_frame(8'(i));
        push_line(1'b1, 1'b1, 1'b0, 1);
        bus_write(2'd2, 32'h1);
        wait_drain(400);
        bus_read(2'd1, 32'h002);

        // Reset mid-frame discards the in-flight and queued bytes
        bus_write(2'd0, 32'h3C);
        bus_write(2'd0, 32'h5A);
        cyc(10);
        push_line(1'b0, 1'b0, 1'b0, 1);
        push_line(1'b1, 1'b1, 1'b0, 40);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        bus_read(2'd1, 32'h002);
        bus_read(2'd2, 32'h001);
        wait_drain(200);
        cyc(2);

        vectors++;
        if (byte_q.size() != 0) begin
            miscompares++;
            $display("FAIL bytes_outstanding count=%0d required=0", byte_q.size());
        end
        vectors++;
        if (rd_q.size() != 0) begin
            miscompares++;
            $display("FAIL reads_outstanding count=%0d required=0", rd_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
